// File: rtl/fsm_pkg.sv
// Shared definitions for the serial transmitter and the "every second 1" detector:
// FSM state encoding, detector state constants and the ones-parity step.
package fsm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Detector states: S0 = even number of ones seen, S1 = odd.
    localparam logic S0 = 1'b0;
    localparam logic S1 = 1'b1;

    typedef struct packed {
        logic next_odd;
        logic pulse;
    } parity_step_t;

    function automatic parity_step_t parity_step(input logic odd, input logic b);
        parity_step_t r;
        r.next_odd = odd ^ b;
        r.pulse    = odd & b;
        return r;
    endfunction

endpackage

// File: rtl/fsm_stream_tx_shifter.sv
// Loadable shift register and bit counter. o_bit is the bit to present at the
// coming edge: the head of i_data while loading, else the head of the remaining word.
module fsm_stream_tx_shifter #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_advance,
    output logic             o_bit,
    output logic             o_last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] r_sreg;
    logic [CW-1:0]    r_bit_cnt;
    logic [WIDTH-1:0] w_src;
    logic [WIDTH-1:0] w_next;
    logic             w_head;

    assign w_src = i_load ? i_data : r_sreg;

    // The register always holds the bits not yet presented, head-aligned.
    generate
        if (MSB_FIRST) begin : g_msb
            assign w_head = w_src[WIDTH-1];
            assign w_next = {w_src[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign w_head = w_src[0];
            assign w_next = {1'b0, w_src[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sreg    <= '0;
            r_bit_cnt <= '0;
        end else if (i_load) begin
            r_sreg    <= w_next;
            r_bit_cnt <= '0;
        end else if (i_advance) begin
            r_sreg    <= w_next;
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    assign o_bit  = w_head;
    assign o_last = (r_bit_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/fsm_stream_tx.sv
// Serial word transmitter feeding the "every second 1" detector, with a registered
// expected-pulse flag aligned to each transmitted bit.
module fsm_stream_tx
    import fsm_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             sync_clr,
    output logic             dout,
    output logic             dout_valid,
    output logic             exp_pulse,
    output logic             busy,
    output logic             done
);

    state_t       r_state;
    logic         r_ones_odd;
    logic         r_dout;
    logic         r_dout_valid;
    logic         r_exp_pulse;
    logic         r_done;
    logic         w_load;
    logic         w_advance;
    logic         w_bit;
    logic         w_last;
    logic         w_odd_eff;
    parity_step_t w_step;

    assign w_load    = (r_state == IDLE) && load_valid;
    assign w_advance = (r_state == SHIFT) && !w_last;

    // A clear in the same IDLE cycle as a load makes the new word start from S0.
    assign w_odd_eff = ((r_state == IDLE) && sync_clr) ? S0 : r_ones_odd;
    assign w_step    = parity_step(w_odd_eff, w_bit);

    fsm_stream_tx_shifter #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shifter (
        .clock     (clock),
        .reset     (reset),
        .i_load    (w_load),
        .i_data    (load_data),
        .i_advance (w_advance),
        .o_bit     (w_bit),
        .o_last    (w_last)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_ones_odd   <= S0;
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
            r_exp_pulse  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (w_load) begin
                        r_state      <= SHIFT;
                        r_dout       <= w_bit;
                        r_dout_valid <= 1'b1;
                        r_exp_pulse  <= w_step.pulse;
                        r_ones_odd   <= w_step.next_odd;
                    end else begin
                        r_dout       <= 1'b0;
                        r_dout_valid <= 1'b0;
                        r_exp_pulse  <= 1'b0;
                        if (sync_clr) begin
                            r_ones_odd <= S0;
                        end
                    end
                end
                SHIFT: begin
                    if (w_last) begin
                        r_state      <= DONE;
                        r_dout       <= 1'b0;
                        r_dout_valid <= 1'b0;
                        r_exp_pulse  <= 1'b0;
                        r_done       <= 1'b1;
                    end else begin
                        r_dout       <= w_bit;
                        r_dout_valid <= 1'b1;
                        r_exp_pulse  <= w_step.pulse;
                        r_ones_odd   <= w_step.next_odd;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state      <= IDLE;
                    r_dout       <= 1'b0;
                    r_dout_valid <= 1'b0;
                    r_exp_pulse  <= 1'b0;
                    r_done       <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign exp_pulse  = r_exp_pulse;
    assign done       = r_done;

endmodule

// File: tb/tb_fsm_stream_tx.sv
// Bench for fsm_stream_tx: an MSB-first and an LSB-first instance share one stimulus
// stream; a counting reference model fills expected queues that a negedge monitor drains.
module tb_fsm_stream_tx;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         load_valid;
    logic [W-1:0] load_data;
    logic         sync_clr;

    logic m_load_ready, m_dout, m_dout_valid, m_exp_pulse, m_busy, m_done;
    logic l_load_ready, l_dout, l_dout_valid, l_exp_pulse, l_busy, l_done;

    fsm_stream_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
        .clock      (clock),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (m_load_ready),
        .sync_clr   (sync_clr),
        .dout       (m_dout),
        .dout_valid (m_dout_valid),
        .exp_pulse  (m_exp_pulse),
        .busy       (m_busy),
        .done       (m_done)
    );

    fsm_stream_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clock      (clock),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (l_load_ready),
        .sync_clr   (sync_clr),
        .dout       (l_dout),
        .dout_valid (l_dout_valid),
        .exp_pulse  (l_exp_pulse),
        .busy       (l_busy),
        .done       (l_done)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;
    logic exp_ready = 1'b1;
    int   next_acc = 0;
    int   n_acc = 0;
    int   ones_m = 0;
    int   ones_l = 0;

    // entry = {cycle[31:0], dout, exp_pulse}
    logic [33:0] exp_q_m[$];
    logic [33:0] exp_q_l[$];
    int          done_q_m[$];
    int          done_q_l[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: acceptance is purely time based, parity is a running count of ones.
    task automatic model_step(input logic v, input logic [W-1:0] d, input logic s);
        exp_ready = (cyc >= next_acc);
        if (exp_ready) begin
            if (s) begin
                ones_m = 0;
                ones_l = 0;
            end
            if (v) begin
                n_acc++;
                next_acc = cyc + W + 2;
                for (int i = 0; i < W; i++) begin
                    logic bm, bl;
                    bm = d[W-1-i];
                    bl = d[i];
                    exp_q_m.push_back({32'(cyc + 1 + i), bm, bm && (ones_m % 2 == 1)});
                    exp_q_l.push_back({32'(cyc + 1 + i), bl, bl && (ones_l % 2 == 1)});
                    ones_m += int'(bm);
                    ones_l += int'(bl);
                end
                done_q_m.push_back(cyc + W + 1);
                done_q_l.push_back(cyc + W + 1);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic v, input logic [W-1:0] d, input logic s);
        @(posedge clock);
        #2;
        load_valid = v;
        load_data  = d;
        sync_clr   = s;
        model_step(v, d, s);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, W'($urandom), 1'b0);
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic s);
        int start;
        start = n_acc;
        while (n_acc == start) step(1'b1, d, s);
    endtask

    // ---------------- reference detector fed by the serial line ----------------
    logic det_s;
    always @(posedge clock or posedge reset) begin
        if (reset) det_s <= 1'b0;
        else if (sync_clr && exp_ready) det_s <= 1'b0;
        else det_s <= det_s ^ m_dout;
    end

    // ---------------- monitor ----------------
    task automatic mon_one(input bit is_l, input logic v, input logic d, input logic p,
                           input logic dn);
        logic [33:0] e;
        int          dc;
        if (v) begin
            if ((is_l ? exp_q_l.size() : exp_q_m.size()) == 0) begin
                chk(is_l ? "extra_bit_l" : "extra_bit_m", v, 1'b0);
            end else begin
                e = is_l ? exp_q_l.pop_front() : exp_q_m.pop_front();
                chk(is_l ? "stream_l" : "stream_m", {cyc, d, p}, e);
            end
        end else begin
            chk(is_l ? "idle_line_l" : "idle_line_m", {d, p}, 2'b00);
        end
        if (dn) begin
            if ((is_l ? done_q_l.size() : done_q_m.size()) == 0) begin
                chk(is_l ? "extra_done_l" : "extra_done_m", dn, 1'b0);
            end else begin
                dc = is_l ? done_q_l.pop_front() : done_q_m.pop_front();
                chk(is_l ? "done_cycle_l" : "done_cycle_m", cyc, dc);
            end
        end
    endtask

    always @(negedge clock) begin
        if (mon_en && !reset) begin
            chk("ready_m", m_load_ready, exp_ready);
            chk("busy_m", m_busy, !exp_ready);
            chk("ready_l", l_load_ready, exp_ready);
            chk("busy_l", l_busy, !exp_ready);
            mon_one(1'b0, m_dout_valid, m_dout, m_exp_pulse, m_done);
            mon_one(1'b1, l_dout_valid, l_dout, l_exp_pulse, l_done);
            chk("loopback", m_exp_pulse, m_dout & det_s);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        sync_clr   = 1'b0;

        repeat (2) @(posedge clock);
        #2;
        chk("rst_ready", m_load_ready, 1'b1);
        chk("rst_valid", m_dout_valid, 1'b0);
        chk("rst_dout", m_dout, 1'b0);
        chk("rst_pulse", m_exp_pulse, 1'b0);
        chk("rst_busy", m_busy, 1'b0);
        chk("rst_done", m_done, 1'b0);
        chk("rst_ready_l", l_load_ready, 1'b1);
        chk("rst_busy_l", l_busy, 1'b0);

        @(posedge clock);
        #2;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Directed word from ones_odd = 0.
        send_word(8'b1011_0001, 1'b0);
        idle(12);

        // Parity carried across words, then cleared between them.
        send_word(8'h01, 1'b0);
        send_word(8'h80, 1'b0);
        idle(12);
        send_word(8'h01, 1'b0);
        idle(10);
        step(1'b0, 8'h00, 1'b1);
        send_word(8'h80, 1'b0);
        idle(12);

        // load_valid held high, data churning while busy.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, (i == 0) ? 8'hFF : (i == 10) ? 8'hAA : W'($urandom), 1'b0);
        end
        idle(12);

        // Asynchronous reset during bit 4 of 8'hFF.
        send_word(8'hFF, 1'b0);
        idle(3);
        @(posedge clock);
        #2;
        mon_en = 1'b0;
        chk("pre_rst_valid", m_dout_valid, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("async_dout", m_dout, 1'b0);
        chk("async_valid", m_dout_valid, 1'b0);
        chk("async_pulse", m_exp_pulse, 1'b0);
        chk("async_busy", m_busy, 1'b0);
        chk("async_valid_l", l_dout_valid, 1'b0);
        chk("async_busy_l", l_busy, 1'b0);
        exp_q_m.delete();
        exp_q_l.delete();
        done_q_m.delete();
        done_q_l.delete();
        ones_m    = 0;
        ones_l    = 0;
        next_acc  = 0;
        load_valid = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        reset     = 1'b0;
        exp_ready = 1'b1;
        chk("post_rst_ready", m_load_ready, 1'b1);
        mon_en = 1'b1;
        send_word(8'hC0, 1'b0);
        idle(12);

        // Random words with random gaps and stray sync_clr pulses.
        for (int w = 0; w < 16; w++) begin
            int gap;
            int start;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                step(1'b0, W'($urandom), ($urandom_range(0, 3) == 0));
            end
            start = n_acc;
            while (n_acc == start) begin
                step(1'b1, W'($urandom), ($urandom_range(0, 4) == 0));
            end
        end
        idle(14);

        @(posedge clock);
        #2;
        mon_en = 1'b0;
        chk("drain_m", exp_q_m.size(), 0);
        chk("drain_l", exp_q_l.size(), 0);
        chk("drain_done_m", done_q_m.size(), 0);
        chk("drain_done_l", done_q_l.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
